// File: rtl/pll_supervisor.sv
// Sequences an iCE40 PLL from the 12 MHz reference: resets it, waits for lock with
// timeout and retries, qualifies lock stability, then releases the 33 MHz core reset.
module pll_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1200,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 8,
    parameter int CNT_W         = 16
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       restart,
    output logic       pll_resetb,
    output logic       core_reset_n,
    output logic       running,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        LOST      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       retry_reg, retry_next;
    logic [7:0]       loss_reg, loss_next;
    logic             sync1_reg, lock_s_reg;
    logic             pll_resetb_reg, core_reset_n_reg, running_reg, fault_reg;

    logic [4:0]       retry_inc;
    logic [3:0]       retry_sat;
    logic             retry_exhausted;
    logic             fail;

    assign retry_inc       = {1'b0, retry_reg} + 5'd1;
    assign retry_sat       = (retry_reg == 4'hF) ? 4'hF : retry_inc[3:0];
    assign retry_exhausted = ({27'd0, retry_inc} >= 32'(MAX_RETRIES));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        fail       = 1'b0;

        // A lock loss in RUN is tallied even when restart overrides the transition.
        if (state_reg == RUN && !lock_s_reg && loss_reg != 8'hFF)
            loss_next = loss_reg + 8'd1;

        if (restart) begin
            state_next = PLL_RST;
            cnt_next   = '0;
            retry_next = '0;
        end else begin
            case (state_reg)
                PLL_RST: begin
                    if (cnt_reg == RST_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s_reg) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        fail = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s_reg) begin
                        fail = 1'b1;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                        retry_next = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s_reg)
                        state_next = LOST;
                end
                LOST: begin
                    state_next = PLL_RST;
                    cnt_next   = '0;
                end
                FAULT: state_next = FAULT;
                default: begin
                    state_next = PLL_RST;
                    cnt_next   = '0;
                end
            endcase

            if (fail) begin
                retry_next = retry_sat;
                cnt_next   = '0;
                state_next = retry_exhausted ? FAULT : PLL_RST;
            end
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= PLL_RST;
            cnt_reg          <= '0;
            retry_reg        <= '0;
            loss_reg         <= '0;
            sync1_reg        <= 1'b0;
            lock_s_reg       <= 1'b0;
            pll_resetb_reg   <= 1'b0;
            core_reset_n_reg <= 1'b0;
            running_reg      <= 1'b0;
            fault_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            retry_reg        <= retry_next;
            loss_reg         <= loss_next;
            sync1_reg        <= locked;
            lock_s_reg       <= sync1_reg;
            pll_resetb_reg   <= (state_next != PLL_RST) && (state_next != FAULT);
            core_reset_n_reg <= (state_next == RUN);
            running_reg      <= (state_next == RUN);
            fault_reg        <= (state_next == FAULT);
        end
    end

    assign pll_resetb   = pll_resetb_reg;
    assign core_reset_n = core_reset_n_reg;
    assign running      = running_reg;
    assign fault        = fault_reg;
    assign state        = state_reg;
    assign retry_count  = retry_reg;
    assign loss_count   = loss_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: hand-derived vector table, directed corner sequences,
// then randomized lock/restart traffic checked against a behavioural model.
module tb_pll_supervisor;

    localparam int RST_C  = 4;
    localparam int TO_C   = 20;
    localparam int STB_C  = 8;
    localparam int MAX_R  = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_resetb, core_reset_n, running, fault;
    logic [2:0] state;
    logic [3:0] retry_count;
    logic [7:0] loss_count;

    int checks = 0;
    int errors = 0;

    pll_supervisor #(
        .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(STB_C),
        .MAX_RETRIES(MAX_R), .CNT_W(16)
    ) dut (
        .clock_in(clk), .reset_n(reset_n), .locked(locked), .restart(restart),
        .pll_resetb(pll_resetb), .core_reset_n(core_reset_n), .running(running),
        .fault(fault), .state(state), .retry_count(retry_count), .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase number, cycles spent in the phase, failed tries,
    // losses, and the last two lock samples (index 1 is the one decisions use).
    int   m_phase, m_elapsed, m_tries, m_losses;
    logic m_hist [2];

    function automatic void model_reset();
        m_phase = 0; m_elapsed = 0; m_tries = 0; m_losses = 0;
        m_hist[0] = 1'b0; m_hist[1] = 1'b0;
    endfunction

    function automatic void model_fail();
        if (m_tries + 1 >= MAX_R) m_phase = 5;
        else m_phase = 0;
        m_elapsed = 0;
        m_tries = (m_tries >= 15) ? 15 : m_tries + 1;
    endfunction

    function automatic void model_step(input logic l, input logic r);
        logic ls;
        ls = m_hist[1];
        if (m_phase == 3 && !ls && m_losses < 255) m_losses++;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_tries = 0;
        end else begin
            case (m_phase)
                0: if (m_elapsed + 1 == RST_C) begin m_phase = 1; m_elapsed = 0; end
                   else m_elapsed++;
                1: if (ls) begin m_phase = 2; m_elapsed = 0; end
                   else if (m_elapsed + 1 == TO_C) model_fail();
                   else m_elapsed++;
                2: if (!ls) model_fail();
                   else if (m_elapsed + 1 == STB_C) begin m_phase = 3; m_elapsed = 0; m_tries = 0; end
                   else m_elapsed++;
                3: if (!ls) m_phase = 4;
                4: begin m_phase = 0; m_elapsed = 0; end
                default: m_phase = 5;
            endcase
        end
        m_hist[1] = m_hist[0];
        m_hist[0] = l;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input logic l, input logic r);
        locked  = l;
        restart = r;
        @(posedge clk);
        model_step(l, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; locked = 1'b0; restart = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_state(input logic [2:0] target, input logic l, input string name);
        int n;
        n = 0;
        while (state !== target && n < 200) begin
            tick(l, 1'b0);
            n++;
        end
        chk(name, int'(state), int'(target));
    endtask

    typedef struct {
        int         n;
        logic       l;
        logic [2:0] st;
        logic       prb;
        logic       crn;
        logic [3:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [18:0] act_v, exp_v;
        int fault_bad;

        // Bring-up, first lock, one-cycle lock drop in RUN and relock.
        tbl[0]  = '{3, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 8'd0};
        tbl[1]  = '{1, 1'b0, 3'd1, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[2]  = '{6, 1'b0, 3'd1, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[3]  = '{2, 1'b1, 3'd1, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[4]  = '{1, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[5]  = '{7, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0};
        tbl[6]  = '{1, 1'b1, 3'd3, 1'b1, 1'b1, 4'd0, 8'd0};
        tbl[7]  = '{1, 1'b0, 3'd3, 1'b1, 1'b1, 4'd0, 8'd0};
        tbl[8]  = '{1, 1'b1, 3'd3, 1'b1, 1'b1, 4'd0, 8'd0};
        tbl[9]  = '{1, 1'b1, 3'd4, 1'b1, 1'b0, 4'd0, 8'd1};
        tbl[10] = '{1, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0, 8'd1};
        tbl[11] = '{4, 1'b1, 3'd1, 1'b1, 1'b0, 4'd0, 8'd1};
        tbl[12] = '{1, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0, 8'd1};
        tbl[13] = '{8, 1'b1, 3'd3, 1'b1, 1'b1, 4'd0, 8'd1};

        do_reset();
        chk("reset_state", int'(state), 0);
        chk("reset_pll_resetb", int'(pll_resetb), 0);
        chk("reset_core_reset_n", int'(core_reset_n), 0);

        for (int i = 0; i < 14; i++) begin
            repeat (tbl[i].n) tick(tbl[i].l, 1'b0);
            chk($sformatf("vec%0d_state", i), int'(state), int'(tbl[i].st));
            chk($sformatf("vec%0d_pll_resetb", i), int'(pll_resetb), int'(tbl[i].prb));
            chk($sformatf("vec%0d_core_reset_n", i), int'(core_reset_n), int'(tbl[i].crn));
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].crn));
            chk($sformatf("vec%0d_retry", i), int'(retry_count), int'(tbl[i].rc));
            chk($sformatf("vec%0d_loss", i), int'(loss_count), int'(tbl[i].lc));
            $display("vec %0d: state=%0d pll_resetb=%0b core_reset_n=%0b retry=%0d loss=%0d",
                     i, state, pll_resetb, core_reset_n, retry_count, loss_count);
        end

        // Restart out of RUN, then three timed-out attempts into FAULT.
        tick(1'b1, 1'b1);
        chk("restart_run_state", int'(state), 0);
        chk("restart_run_loss", int'(loss_count), 1);
        chk("restart_run_core", int'(core_reset_n), 0);
        repeat (71) tick(1'b0, 1'b0);
        chk("third_attempt_state", int'(state), 1);
        chk("third_attempt_retry", int'(retry_count), 2);
        tick(1'b0, 1'b0);
        chk("fault_state", int'(state), 5);
        chk("fault_flag", int'(fault), 1);
        chk("fault_retry", int'(retry_count), 3);
        fault_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1'b0, 1'b0);
            if (state !== 3'd5 || pll_resetb !== 1'b0 || core_reset_n !== 1'b0) fault_bad++;
        end
        chk("fault_hold_bad_cycles", fault_bad, 0);
        $display("fault sequence: state=%0d retry=%0d", state, retry_count);

        // Restart out of FAULT keeps the loss tally.
        tick(1'b0, 1'b1);
        chk("restart_fault_state", int'(state), 0);
        chk("restart_fault_flag", int'(fault), 0);
        chk("restart_fault_retry", int'(retry_count), 0);
        chk("restart_fault_loss", int'(loss_count), 1);
        $display("restart from fault: state=%0d loss=%0d", state, loss_count);

        // Two lock glitches during STABLE, then a clean lock.
        for (int g = 1; g <= 2; g++) begin
            wait_state(3'd2, 1'b1, "glitch_reach_stable");
            repeat (2) tick(1'b1, 1'b0);
            wait_state(3'd0, 1'b0, "glitch_back_to_rst");
            chk($sformatf("glitch%0d_retry", g), int'(retry_count), g);
            $display("glitch %0d: state=%0d retry=%0d", g, state, retry_count);
        end
        wait_state(3'd3, 1'b1, "glitch_final_run");
        chk("glitch_run_retry", int'(retry_count), 0);
        chk("glitch_no_fault", int'(fault), 0);

        // Asynchronous reset landing between edges in STABLE.
        tick(1'b1, 1'b1);
        wait_state(3'd2, 1'b1, "async_reach_stable");
        repeat (2) tick(1'b1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_pll_resetb", int'(pll_resetb), 0);
        chk("async_core_reset_n", int'(core_reset_n), 0);
        chk("async_running", int'(running), 0);
        chk("async_fault", int'(fault), 0);
        chk("async_retry", int'(retry_count), 0);
        chk("async_loss", int'(loss_count), 0);
        $display("async reset: state=%0d loss=%0d", state, loss_count);

        // Randomized lock runs with occasional restarts against the model.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int   len;
            logic lvl;
            int   seg_err;
            len = $urandom_range(1, 100);
            lvl = ($urandom_range(0, 9) < 6);
            seg_err = errors;
            for (int c = 0; c < len; c++) begin
                logic r;
                r = ($urandom_range(0, 199) == 0);
                tick(lvl, r);
                act_v = {state, pll_resetb, core_reset_n, running, fault, retry_count, loss_count};
                exp_v = {3'(m_phase), (m_phase != 0 && m_phase != 5), (m_phase == 3),
                         (m_phase == 3), (m_phase == 5), 4'(m_tries), 8'(m_losses)};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL rand_seg%0d_cyc%0d: got %h expected %h", seg, c, act_v, exp_v);
                end
            end
            $display("rand seg %0d: locked=%0b len=%0d state=%0d retry=%0d loss=%0d new_errors=%0d",
                     seg, lvl, len, state, retry_count, loss_count, errors - seg_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Sequences the iCE40 PLL (12 MHz reference in, 33 MHz LPC sample clock out).
- Pulses the PLL reset, waits for lock with a timeout and retries, and qualifies lock as stable before releasing the core reset.
- Detects loss of lock in service and restarts the sequence.
- Runs entirely on the 12 MHz reference clock, because the PLL output is not trustworthy until lock.

Parameters:
- RST_CYCLES, 16: clock_in cycles for which pll_resetb is held low per attempt (min 1).
- LOCK_TIMEOUT, 1200: clock_in cycles to wait for synchronized lock before retrying (100 us).
- STABLE_CYCLES, 256: consecutive cycles lock must stay high before core reset is released.
- MAX_RETRIES, 8: failed attempts (timeouts or stability failures) before entering FAULT.
- CNT_W, 16: width of the internal cycle counter; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clock_in  input  1  12 MHz reference clock.
- reset_n  input  1  Asynchronous active-low reset.
- locked  input  1  PLL LOCK, asynchronous to clock_in.
- restart  input  1  Single-cycle request to restart the sequence from any state.
- pll_resetb  output  1  Drives PLL RESETB; low holds the PLL in reset.
- core_reset_n  output  1  Active-low reset for the 33 MHz domain. The consumer synchronizes its deassertion.
- running  output  1  High only in RUN.
- fault  output  1  High only in FAULT.
- state  output  3  Current state encoding.
- retry_count  output  4  Failed attempts since the last entry into RUN; saturates at 15.
- loss_count  output  8  Lock losses observed while in RUN; saturates at 255; cleared only by reset_n.

Behaviour:
- All outputs are registered.
- reset_n low (asynchronous) forces:
  - state = PLL_RST (0)
  - pll_resetb = 0, core_reset_n = 0, running = 0, fault = 0
  - retry_count = 0, loss_count = 0, counter = 0
  - both synchronizer flops = 0
- locked passes through a 2-flop synchronizer to give lock_s. Every lock decision uses lock_s, so there are 2 cycles of latency from locked.
- State encodings:
  - PLL_RST = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3, LOST = 4, FAULT = 5.
- PLL_RST:
  - pll_resetb = 0. Counter counts 0 to RST_CYCLES-1.
  - At the terminal count: go to WAIT_LOCK and clear the counter.
  - pll_resetb is therefore low for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_resetb = 1. Counter increments each cycle.
  - If lock_s = 1: go to STABLE and clear the counter.
  - Else at count LOCK_TIMEOUT-1: this is a failed attempt.
- STABLE:
  - If lock_s = 0: failed attempt.
  - Else at count STABLE_CYCLES-1: go to RUN. core_reset_n goes to 1 and running to 1 in the same registered update. Clear retry_count.
- Failed attempt handling:
  - Increment retry_count (saturating).
  - If the pre-increment retry_count + 1 >= MAX_RETRIES: go to FAULT.
  - Otherwise go to PLL_RST and clear the counter.
- RUN:
  - core_reset_n = 1.
  - If lock_s = 0: go to LOST. core_reset_n drops to 0 on that same edge. Increment loss_count (saturating).
- LOST:
  - One cycle, core_reset_n = 0. Then go to PLL_RST.
  - A lock loss does not count toward retry_count.
- FAULT:
  - pll_resetb = 0, core_reset_n = 0, fault = 1.
  - Held until restart or reset_n.
- restart:
  - Priority is reset_n > restart > all other transitions.
  - From any state: go to PLL_RST, counter = 0, retry_count = 0, core_reset_n = 0, running = 0, fault = 0.
  - loss_count is preserved.
  - restart asserted on the same cycle as a lock loss in RUN: restart wins and loss_count still increments.
- core_reset_n is 0 in every state except RUN.
- lock_s glitch high-low within WAIT_LOCK:
  - The first high moves the block to STABLE.
  - The subsequent low in STABLE is a failed attempt. WAIT_LOCK is not re-entered.
- retry_count saturates at 15 regardless of MAX_RETRIES.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=3.
1. reset_n released; locked rises at cycle 10 and stays high
   -> pll_resetb low cycles 0-3; state enters STABLE 2 cycles after locked rises; RUN 8 cycles later; core_reset_n = 1; retry_count = 0.
2. locked held 0 throughout
   -> three 4+20 cycle attempts; retry_count = 3; FAULT after the third timeout; fault = 1; pll_resetb = 0 held for 100 cycles.
3. Block in RUN; locked drops for 1 cycle
   -> 2 cycles later state = LOST, core_reset_n = 0, loss_count = 1; next cycle PLL_RST; relock reaches RUN again.
4. locked toggles high 3 cycles then low during STABLE, twice, then stays high
   -> retry_count reaches 2, then RUN entered and retry_count cleared to 0; no FAULT.
5. In FAULT, pulse restart
   -> next cycle state = PLL_RST, fault = 0, retry_count = 0, loss_count unchanged.
6. reset_n asserted mid-STABLE, asynchronously between edges
   -> outputs reach reset values immediately without a clock edge; loss_count = 0.
